simple_dual_ram: RTL

- Parametrised successor to the team's single-port RAM.
- Separate write and read ports share one clock, so a frame can be written while display scan-out reads it (e.g. LED matrix frame buffer).
- Adds per-lane byte enables, a read-enable/valid handshake, selectable read latency (1 or 2) and a selectable read-during-write policy.
- Memory array is coded so the tools infer block RAM.

---
 rtl/simple_dual_ram_if.sv | 45 ++++
 rtl/simple_dual_ram.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/simple_dual_ram_if.sv
// simple_dual_ram_if
//   Bundles the write port and the read port of simple_dual_ram. The clock
//   and the reset stay plain module ports.
//
//   Parameters: WIDTH (word bits), DEPTH (words), LANE_W (bits per lane).
//
//   Write side: wr_en, wr_addr, wr_data, wr_be (one enable bit per lane).
//   Read side : rd_en, rd_addr in; rd_data, rd_valid, parity_err out.
//
//   Handshake: the RAM is always ready. A read is accepted on every rising
//   edge where rd_en=1. Exactly RD_LATENCY cycles later, rd_valid is high for
//   one cycle, and rd_data/parity_err belong to that read. Results come back
//   in request order. Writes need no handshake: they take effect on the edge
//   where wr_en=1.
//
//   Modports: master drives requests (the bench or the client logic); slave
//   is the RAM.
interface simple_dual_ram_if #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 64,
  parameter int LANE_W = 8
);
  localparam int LANES = WIDTH / LANE_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [LANES-1:0] wr_be;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             parity_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, parity_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, parity_err
  );
endinterface

// File: rtl/simple_dual_ram.sv
// simple_dual_ram
//   This is a simple dual-port RAM. It has one write port and one read port,
//   and both ports run on the same clock. A typical use is a frame buffer
//   that is written while display scan-out reads it.
//
//   Features:
//     - per-lane byte enables
//     - rd_en/rd_valid read handshake
//     - RD_LATENCY of 1 or 2
//     - RDW_NEW sets the result when a read and a write hit the same address
//       in the same cycle: 0 gives the old word, 1 gives the lane-merged new
//       word.
//
//   The array is read-first and has no reset, so the tools can map it to
//   block RAM. The RDW_NEW=1 merge comes from a small bypass register that
//   sits beside the array output. The array itself is not changed for it.
//
//   Optional feature: define SIMPLE_DUAL_RAM_PARITY_EN to add one even-parity
//   bit per lane. The parity bit is stored next to the data and checked on
//   read. When the macro is undefined, parity_err is tied to 0.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset. It clears the read pipeline and
//             the outputs. The memory contents are kept.
//     bus   : simple_dual_ram_if.slave. Carries the wr_* and rd_* signals,
//             plus parity_err.
module simple_dual_ram #(
  parameter int WIDTH      = 24,
  parameter int DEPTH      = 64,
  parameter int LANE_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_NEW    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  simple_dual_ram_if.slave    bus
);
  localparam int LANES = WIDTH / LANE_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One bit wider than the address, so DEPTH is representable even when it
  // is a power of two.
  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("simple_dual_ram: RD_LATENCY must be 1 or 2");
  end
  if (WIDTH % LANE_W != 0) begin : g_bad_lanes
    $error("simple_dual_ram: WIDTH must be a multiple of LANE_W");
  end

  // ---------------------------------------------------------------------
  // Address qualification
  // ---------------------------------------------------------------------
  logic wr_ok;
  logic rd_ok;
  logic rdw_hit;

  assign wr_ok   = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_LIM);
  assign rd_ok   = {1'b0, bus.rd_addr} < DEPTH_LIM;
  // A same-address collision only matters when the new data should win.
  assign rdw_hit = (RDW_NEW != 0) && wr_ok && rd_ok &&
                   (bus.wr_addr == bus.rd_addr);

  // ---------------------------------------------------------------------
  // Storage (no reset, read-first)
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.wr_be[i]) begin
          mem[bus.wr_addr][i*LANE_W +: LANE_W] <= bus.wr_data[i*LANE_W +: LANE_W];
        end
      end
    end
    if (bus.rd_en && rd_ok) begin
      ram_q <= mem[bus.rd_addr];
    end
  end

  // Even parity of each incoming lane. With parity disabled it is unused
  // except for the bypass register.
  logic [LANES-1:0] wr_par;

  always_comb begin
    wr_par = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_par[i] = ^bus.wr_data[i*LANE_W +: LANE_W];
    end
  end

`ifdef SIMPLE_DUAL_RAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] par_q;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.wr_be[i]) begin
          par_mem[bus.wr_addr][i] <= wr_par[i];
        end
      end
    end
    if (bus.rd_en && rd_ok) begin
      par_q <= par_mem[bus.rd_addr];
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Read stage 1: valid, out-of-range flag and new-data bypass
  // ---------------------------------------------------------------------
  logic             s1_valid;
  logic             s1_oor;
  logic             have_data;   // low until the first read after reset
  logic [LANES-1:0] byp_mask;
  logic [WIDTH-1:0] byp_data;
  logic [LANES-1:0] byp_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_oor    <= 1'b0;
      have_data <= 1'b0;
      byp_mask  <= '0;
      byp_data  <= '0;
      byp_par   <= '0;
    end else begin
      s1_valid <= bus.rd_en;
      if (bus.rd_en) begin
        have_data <= 1'b1;
        s1_oor    <= !rd_ok;
        byp_mask  <= rdw_hit ? bus.wr_be : '0;
        byp_data  <= bus.wr_data;
        byp_par   <= wr_par;
      end
    end
  end

  // Merge the array word with the bypassed lanes, then check parity.
  // Every stage-1 register only loads on an accepted read. Because of that,
  // word1 holds its value between reads.
  logic [WIDTH-1:0] word1;
  logic             err1;
  logic [LANES-1:0] stored_par;

  always_comb begin
    word1      = '0;
    err1       = 1'b0;
    stored_par = '0;
`ifdef SIMPLE_DUAL_RAM_PARITY_EN
    stored_par = par_q;
`endif
    for (int i = 0; i < LANES; i++) begin
      if (byp_mask[i]) begin
        word1[i*LANE_W +: LANE_W] = byp_data[i*LANE_W +: LANE_W];
        stored_par[i]             = byp_par[i];
      end else begin
        word1[i*LANE_W +: LANE_W] = ram_q[i*LANE_W +: LANE_W];
      end
    end
    if (s1_oor || !have_data) begin
      word1      = '0;
      stored_par = '0;
    end
`ifdef SIMPLE_DUAL_RAM_PARITY_EN
    for (int i = 0; i < LANES; i++) begin
      if ((^word1[i*LANE_W +: LANE_W]) != stored_par[i]) begin
        err1 = 1'b1;
      end
    end
`else
    err1 = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------
  // Output: direct from stage 1, or through one more register stage
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_valid_o;
  logic             parity_err_o;

  if (RD_LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_perr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_data  <= '0;
        out_valid <= 1'b0;
        out_perr  <= 1'b0;
      end else begin
        out_valid <= s1_valid;
        out_perr  <= s1_valid && err1;
        if (s1_valid) begin
          out_data <= word1;
        end
      end
    end

    assign rd_data_o    = out_data;
    assign rd_valid_o   = out_valid;
    assign parity_err_o = out_perr;
  end else begin : g_lat1
    assign rd_data_o    = word1;
    assign rd_valid_o   = s1_valid;
    assign parity_err_o = s1_valid && err1;
  end

  assign bus.rd_data    = rd_data_o;
  assign bus.rd_valid   = rd_valid_o;
  assign bus.parity_err = parity_err_o;
endmodule
